pulse_measure: RTL
==================

// Module: pulse_measure
// PURPOSE
//  Receive-side companion to delay_pulse / pulse_stretch: recovers timing from a pulse stream.
//  Per pulse: flags the rising edge, measures high width and rising-edge period in clk cycles.
//  Sits behind PPS / timing-pulse inputs (already synchronised to clk) for discipline logic.
// PARAMETERS
//  CNT_SIZE    16  width of width/period counters and outputs
//  MIN_CYCLES  2   minimum accepted high width (used only with PULSE_MEASURE_GLITCH_EN)
// PORTS
//  clk          in   1         system clock, all logic rising-edge
//  rst_n        in   1         async active-low reset
//  d            in   1         pulse input, synchronous to clk
//  start        out  1         1-cycle strobe: rising edge of d accepted
//  width        out  CNT_SIZE  last measured high width (cycles), held until next update
//  width_valid  out  1         1-cycle strobe: width updated this cycle
//  width_ovf    out  1         width saturated; updated with width_valid
//  period       out  CNT_SIZE  rise-to-rise distance (cycles), held until next update
//  period_valid out  1         1-cycle strobe: period updated this cycle
//  period_ovf   out  1         period saturated; updated with period_valid
//  glitch       out  1         1-cycle strobe: pulse rejected as too short (0 without macro)
// BEHAVIOUR
//  Reset: one clock, async active-low reset, all regs cleared on rst_n=0 regardless of clk:
//   state=IDLE, all outputs 0, wcnt=0, pcnt=0, seen=0.
//  All outputs registered; strobes are high exactly one cycle.
//  Width FSM, evaluated at each clk edge:
//   IDLE: d=1 -> HIGH, wcnt<=1, start<=1. d=0 -> stay.
//   HIGH: d=1 -> wcnt<=sat(wcnt+1). d=0 -> IDLE, width<=wcnt, width_valid<=1,
//         width_ovf<=(wcnt==all-ones).
//  Width = number of clk edges d sampled high; 1-cycle pulse gives width=1.
//  start and width_valid appear the cycle after the first / last-plus-one sample.
//  Back-to-back d=1,0,1: start, width_valid(1), start on consecutive edges; no pulse lost.
//  Period: pcnt counts every edge, saturates at all-ones (no wrap).
//   On accepted rise (IDLE & d=1): pcnt<=1.
//   If seen=1: period<=pcnt, period_valid<=1, period_ovf<=(pcnt==all-ones).
//   seen<=1. First rise after reset gives no period_valid.
//  Saturation: counters stick at 2**CNT_SIZE-1 until reloaded. width/period output that value.
//  d held high forever: no width_valid; wcnt sits saturated.
//  Reset mid-pulse: pulse discarded. If d still 1 after release, counts as a new rise (start=1).
//  start and period_valid assert on the same edge for every rise after the first.
// CONFIGURATION
//  PULSE_MEASURE_GLITCH_EN defined:
//   HIGH->IDLE with wcnt<MIN_CYCLES: glitch<=1, width_valid=0, width/width_ovf unchanged.
//   start and period updates for that pulse are unaffected.
//   MIN_CYCLES<=1 disables rejection.
//  Not defined: every pulse reports width_valid; glitch tied 0; MIN_CYCLES ignored.
// TESTING
//  Reset 1001 ps, 100 MHz clk, d=0 -> all outputs 0, no strobes for 200 cycles.
//  1-cycle pulse then 64 low -> start, next edge width_valid width=1; no period_valid (first rise).
//  Pulses high 3, period 10, repeated x4 -> width=3 each; period_valid x3, period=10.
//  Pulse train: 1-cycle pulse then j low, j=0..32 -> period=j+1, width=1 every pulse,
//   except j=0 merges adjacent pulses (width=2).
//  CNT_SIZE=4, d high 20 cycles -> width=15, width_ovf=1.
//   Rise gap 40 -> period=15, period_ovf=1.
//  With PULSE_MEASURE_GLITCH_EN, MIN_CYCLES=2: 1-cycle pulse -> glitch=1, width unchanged.
//   3-cycle pulse -> width_valid width=3. Without macro: both pulses give width_valid.
//  rst_n low mid-pulse (d high) for 3 cycles -> outputs 0; on release start=1, no period_valid.

Source files
------------

// File: rtl/pulse_measure.sv
// pulse_measure: receive-side pulse timing recovery.
//
// Watches a pulse stream that is already synchronous to clk. For every pulse it
// flags the accepted rising edge, measures the high width and the rise-to-rise
// period, all in clk cycles. Both counters saturate at all-ones instead of
// wrapping, and an overflow flag is reported alongside each measurement.
//
// Optional feature (compile-time macro PULSE_MEASURE_GLITCH_EN):
//   Pulses whose high width is below MIN_CYCLES are rejected. A rejected pulse
//   raises glitch for one cycle instead of width_valid, and width/width_ovf keep
//   their previous values. Its rising edge still produces start and a period
//   update. MIN_CYCLES <= 1 disables rejection. Without the macro, every pulse
//   reports width_valid and glitch is tied low.
//
// Parameters:
//   CNT_SIZE     width of the width/period counters and outputs
//   MIN_CYCLES   minimum accepted high width (only with PULSE_MEASURE_GLITCH_EN)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   d             pulse input, synchronous to clk
//   start         1-cycle strobe: rising edge of d accepted
//   width         last measured high width, held until the next update
//   width_valid   1-cycle strobe: width updated this cycle
//   width_ovf     width saturated; updated together with width_valid
//   period        last rise-to-rise distance, held until the next update
//   period_valid  1-cycle strobe: period updated this cycle
//   period_ovf    period saturated; updated together with period_valid
//   glitch        1-cycle strobe: pulse rejected as too short

module pulse_measure #(
  parameter int unsigned CNT_SIZE   = 16,
  parameter int unsigned MIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d,
  output logic                start,
  output logic [CNT_SIZE-1:0] width,
  output logic                width_valid,
  output logic                width_ovf,
  output logic [CNT_SIZE-1:0] period,
  output logic                period_valid,
  output logic                period_ovf,
  output logic                glitch
);

  localparam logic [CNT_SIZE-1:0] CntMax = '1;
  localparam logic [CNT_SIZE-1:0] CntOne = CNT_SIZE'(1);

`ifdef PULSE_MEASURE_GLITCH_EN
  localparam bit GlitchEn = 1'b1;
`else
  localparam bit GlitchEn = 1'b0;
`endif

  typedef enum logic [0:0] {
    StIdle,
    StHigh
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_SIZE-1:0] wcnt_q, wcnt_d;
  logic [CNT_SIZE-1:0] pcnt_q, pcnt_d;
  logic                seen_q, seen_d;

  logic                start_q, start_d;
  logic [CNT_SIZE-1:0] width_q, width_d;
  logic                width_valid_q, width_valid_d;
  logic                width_ovf_q, width_ovf_d;
  logic [CNT_SIZE-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                period_ovf_q, period_ovf_d;
  logic                glitch_q, glitch_d;

  // Saturating increments: both counters stick at all-ones until reloaded.
  logic [CNT_SIZE-1:0] wcnt_inc;
  logic [CNT_SIZE-1:0] pcnt_inc;

  assign wcnt_inc = (wcnt_q == CntMax) ? wcnt_q : wcnt_q + CntOne;
  assign pcnt_inc = (pcnt_q == CntMax) ? pcnt_q : pcnt_q + CntOne;

  // A pulse ending now is too short when its sampled high count is below the
  // minimum. wcnt is at least 1 in StHigh, so MIN_CYCLES <= 1 never rejects.
  logic too_short;

`ifdef PULSE_MEASURE_GLITCH_EN
  assign too_short = (MIN_CYCLES > 1) && (32'(wcnt_q) < MIN_CYCLES);
`else
  assign too_short = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    pcnt_d         = pcnt_inc;
    seen_d         = seen_q;
    start_d        = 1'b0;
    width_d        = width_q;
    width_valid_d  = 1'b0;
    width_ovf_d    = width_ovf_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    period_ovf_d   = period_ovf_q;
    glitch_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d) begin
          state_d = StHigh;
          wcnt_d  = CntOne;
          start_d = 1'b1;
          // Period restarts at 1 on the rising edge; the first rise after reset
          // only arms the measurement.
          pcnt_d  = CntOne;
          seen_d  = 1'b1;
          if (seen_q) begin
            period_d       = pcnt_q;
            period_valid_d = 1'b1;
            period_ovf_d   = (pcnt_q == CntMax);
          end
        end
      end

      StHigh: begin
        if (d) begin
          wcnt_d = wcnt_inc;
        end else begin
          state_d = StIdle;
          if (too_short) begin
            glitch_d = 1'b1;
          end else begin
            width_d       = wcnt_q;
            width_valid_d = 1'b1;
            width_ovf_d   = (wcnt_q == CntMax);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wcnt_q         <= '0;
      pcnt_q         <= '0;
      seen_q         <= 1'b0;
      start_q        <= 1'b0;
      width_q        <= '0;
      width_valid_q  <= 1'b0;
      width_ovf_q    <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      period_ovf_q   <= 1'b0;
      glitch_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      pcnt_q         <= pcnt_d;
      seen_q         <= seen_d;
      start_q        <= start_d;
      width_q        <= width_d;
      width_valid_q  <= width_valid_d;
      width_ovf_q    <= width_ovf_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      period_ovf_q   <= period_ovf_d;
      glitch_q       <= glitch_d;
    end
  end

  assign start        = start_q;
  assign width        = width_q;
  assign width_valid  = width_valid_q;
  assign width_ovf    = width_ovf_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign period_ovf   = period_ovf_q;
  assign glitch       = glitch_q;

`ifndef SYNTHESIS
  // A period is only ever reported on an accepted rising edge.
  a_period_on_start : assert property (@(posedge clk) disable iff (!rst_n)
    period_valid |-> start);

  // Pulse end and pulse start are different FSM states, so they never coincide.
  a_end_not_start : assert property (@(posedge clk) disable iff (!rst_n)
    width_valid |-> !start);

  // A pulse ends either accepted or rejected, never both.
  a_glitch_excl : assert property (@(posedge clk) disable iff (!rst_n)
    glitch |-> (!width_valid && !start));

  // Accepted widths respect the minimum whenever rejection is active.
  a_min_width : assert property (@(posedge clk) disable iff (!rst_n)
    width_valid |-> (!GlitchEn || (MIN_CYCLES <= 1) || (32'(width) >= MIN_CYCLES)));
`endif

endmodule
